// File: rtl/b4to2_rr_encoder.sv
// Registered 4-to-2 request encoder with round-robin arbitration and a valid/ack handshake.
// z1_z0/v drive a 2-to-4 enable decoder directly: code to select, valid to enable.
module b4to2_rr_encoder (
  input  logic       clock,
  input  logic       reset_,
  input  logic [3:0] r3_r0,
  input  logic       ack,
  output logic [1:0] z1_z0,
  output logic       v,
  output logic [3:0] p3_p0
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state_reg;
  logic [1:0] last_reg;
  logic [1:0] z_reg;
  logic       v_reg;
  logic [3:0] p_reg;

  logic       accept;
  logic [3:0] clr;
  logic [3:0] p_next;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] sel_idx;
  logic       any_pend;

  assign accept   = (state_reg == OFFER) && ack;
  assign any_pend = |p_reg;

  // rot[k] is the pending bit at search position k, i.e. line last+1+k (mod 4).
  // A new request on the line being cleared wins, so OR-in happens after the clear.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_line
      logic [1:0] src_idx;
      assign src_idx     = last_reg + 2'(gi + 1);
      assign rot[gi]     = p_reg[src_idx];
      assign clr[gi]     = accept && (z_reg == 2'(gi));
      assign p_next[gi]  = (p_reg[gi] & ~clr[gi]) | r3_r0[gi];
    end
  endgenerate

  always_comb begin
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign sel_idx = last_reg + 2'd1 + off;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_reg <= IDLE;
      last_reg  <= 2'b11;
      z_reg     <= 2'b00;
      v_reg     <= 1'b0;
      p_reg     <= 4'b0000;
    end else begin
      p_reg <= p_next;
      case (state_reg)
        IDLE: begin
          // Selection sees only the registered pending set, not this edge's requests.
          if (any_pend) begin
            z_reg     <= sel_idx;
            v_reg     <= 1'b1;
            state_reg <= OFFER;
          end
        end
        OFFER: begin
          if (ack) begin
            last_reg  <= z_reg;
            v_reg     <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          v_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign z1_z0 = z_reg;
  assign v     = v_reg;
  assign p3_p0 = p_reg;

endmodule

// File: tb/tb_b4to2_rr_encoder.sv
// Bench for b4to2_rr_encoder: vector table, hand-written corner sequences,
// and randomized traffic against a behavioural pending-set/round-robin model.
module tb_b4to2_rr_encoder;

  logic       clock;
  logic       reset_;
  logic [3:0] r3_r0;
  logic       ack;
  logic [1:0] z1_z0;
  logic       v;
  logic [3:0] p3_p0;

  int checks = 0;
  int errors = 0;

  b4to2_rr_encoder dut (
    .clock (clock),
    .reset_(reset_),
    .r3_r0 (r3_r0),
    .ack   (ack),
    .z1_z0 (z1_z0),
    .v     (v),
    .p3_p0 (p3_p0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] r;
    logic       a;
    logic       ev;
    logic [1:0] ez;
    logic [3:0] ep;
  } vec_t;

  vec_t tbl[18];

  // Behavioural model: pending lines, last grant, offer flag and offered code.
  bit m_pend[4];
  int m_last;
  bit m_offer;
  int m_code;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_last  = 3;
    m_offer = 1'b0;
    m_code  = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic a);
    bit nxt[4];
    for (int i = 0; i < 4; i++)
      nxt[i] = (m_pend[i] && !(m_offer && a && m_code == i)) || r[i];
    if (!m_offer) begin
      for (int k = 1; k <= 4; k++) begin
        if (!m_offer && m_pend[(m_last + k) % 4]) begin
          m_code  = (m_last + k) % 4;
          m_offer = 1'b1;
        end
      end
    end else if (a) begin
      m_last  = m_code;
      m_offer = 1'b0;
    end
    for (int i = 0; i < 4; i++) m_pend[i] = nxt[i];
  endtask

  function automatic logic [3:0] model_p();
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic step(input logic [3:0] r, input logic a);
    r3_r0 = r;
    ack   = a;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    r3_r0  = 4'b0000;
    ack    = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_v", {3'b0, v}, 4'b0000);
    chk("reset_z", {2'b0, z1_z0}, 4'b0000);
    chk("reset_p", p3_p0, 4'b0000);
    reset_ = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] grants[$];
    logic       prev_v;
    logic [3:0] rr;
    logic       aa;

    // r, ack, expected v, z, p after the edge
    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 2'b00, 4'b0100};
    tbl[1]  = '{4'b0000, 1'b0, 1'b1, 2'b10, 4'b0100};
    tbl[2]  = '{4'b0000, 1'b0, 1'b1, 2'b10, 4'b0100};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 2'b10, 4'b0100};
    tbl[4]  = '{4'b0000, 1'b0, 1'b1, 2'b10, 4'b0100};
    tbl[5]  = '{4'b0000, 1'b0, 1'b1, 2'b10, 4'b0100};
    tbl[6]  = '{4'b0000, 1'b0, 1'b1, 2'b10, 4'b0100};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 2'b10, 4'b0000};
    tbl[8]  = '{4'b1111, 1'b1, 1'b0, 2'b10, 4'b1111};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 2'b11, 4'b1111};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 2'b11, 4'b0111};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 2'b00, 4'b0111};
    tbl[12] = '{4'b0000, 1'b1, 1'b0, 2'b00, 4'b0110};
    tbl[13] = '{4'b0000, 1'b1, 1'b1, 2'b01, 4'b0110};
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 2'b01, 4'b0100};
    tbl[15] = '{4'b0000, 1'b1, 1'b1, 2'b10, 4'b0100};
    tbl[16] = '{4'b0000, 1'b1, 1'b0, 2'b10, 4'b0000};
    tbl[17] = '{4'b0000, 1'b1, 1'b0, 2'b10, 4'b0000};

    reset_ = 1'b0;
    r3_r0  = 4'b0000;
    ack    = 1'b0;
    #12;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].a);
      $display("vec %0d: r=%b ack=%b -> v=%b z=%b p=%b", i, tbl[i].r, tbl[i].a, v, z1_z0, p3_p0);
      chk($sformatf("vec%0d_v", i), {3'b0, v}, {3'b0, tbl[i].ev});
      chk($sformatf("vec%0d_z", i), {2'b0, z1_z0}, {2'b0, tbl[i].ez});
      chk($sformatf("vec%0d_p", i), p3_p0, tbl[i].ep);
    end

    // All four pulsed once after reset, ack held: grants 0,1,2,3 with gaps.
    do_reset();
    prev_v = 1'b0;
    for (int e = 0; e < 9; e++) begin
      step((e == 0) ? 4'b1111 : 4'b0000, 1'b1);
      if (v && !prev_v) grants.push_back(z1_z0);
      if (v && prev_v) chk("burst_gap", 4'b0001, 4'b0000);
      prev_v = v;
    end
    $display("burst: %0d grants", grants.size());
    chk("burst_count", 4'(grants.size()), 4'd4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk($sformatf("burst_grant%0d", k), {2'b0, grants[k]}, 4'(k));
    chk("burst_p_end", p3_p0, 4'b0000);

    // last=00 then pend 1001: 11 must be offered before 00.
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b0000, 1'b0);
    $display("rr: first offer v=%b z=%b", v, z1_z0);
    chk("rr_first", {1'b0, v, z1_z0}, 4'b0111);
    step(4'b0000, 1'b1);
    chk("rr_p_mid", p3_p0, 4'b0001);
    step(4'b0000, 1'b0);
    $display("rr: second offer v=%b z=%b", v, z1_z0);
    chk("rr_second", {1'b0, v, z1_z0}, 4'b0100);

    // Request on the line being acked in the same edge survives.
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    chk("merge_offer", {1'b0, v, z1_z0}, 4'b0101);
    step(4'b0100, 1'b0);
    step(4'b0010, 1'b1);
    $display("merge: v=%b p=%b", v, p3_p0);
    chk("merge_p", p3_p0, 4'b0110);
    chk("merge_v", {3'b0, v}, 4'b0000);
    step(4'b0000, 1'b0);
    chk("merge_next", {1'b0, v, z1_z0}, 4'b0110);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    chk("merge_after", {1'b0, v, z1_z0}, 4'b0101);

    // ack while idle changes nothing.
    do_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    $display("idle_ack: v=%b z=%b p=%b", v, z1_z0, p3_p0);
    chk("idle_ack_state", {1'b0, v, z1_z0}, 4'b0000);
    chk("idle_ack_p", p3_p0, 4'b0000);
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    chk("idle_ack_grant", {1'b0, v, z1_z0}, 4'b0100);

    // Asynchronous reset in the middle of an offer.
    do_reset();
    step(4'b1010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    chk("areset_pre", {1'b0, v, z1_z0}, 4'b0101);
    chk("areset_pre_p", p3_p0, 4'b1011);
    #2;
    reset_ = 1'b0;
    #1;
    $display("areset: v=%b z=%b p=%b", v, z1_z0, p3_p0);
    chk("areset_vz", {1'b0, v, z1_z0}, 4'b0000);
    chk("areset_p", p3_p0, 4'b0000);
    @(posedge clock);
    #1;
    reset_ = 1'b1;
    model_reset();
    for (int e = 0; e < 4; e++) begin
      step(4'b0000, 1'b0);
      chk($sformatf("areset_after%0d", e), {3'b0, v}, 4'b0000);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if (c % 500 < 40) rr = 4'b1111;
      aa = ($urandom_range(0, 2) != 0);
      step(rr, aa);
      model_step(rr, aa);
      if (v && aa === 1'b0 && 0) ;
      chk("rand_v", {3'b0, v}, {3'b0, m_offer});
      chk("rand_z", {2'b0, z1_z0}, 4'(m_code));
      chk("rand_p", p3_p0, model_p());
      if (c % 100 == 0)
        $display("rand %0d: r=%b ack=%b v=%b z=%b p=%b", c, rr, aa, v, z1_z0, p3_p0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
